mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch
// and the load/store unit, with alternating fairness and a wait timeout.
module mem_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [3:0]  ls_bmask,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic [31:0] ls_rdata,
   output logic        ls_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_bmask,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        stall_if,
   output logic        stall_mem,
   output logic        err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_IF,
      S_LS
   } state_t;

   localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

   state_t      r_state;
   state_t      w_next;
   logic        r_last_ls;
   logic [7:0]  r_cnt;
   logic        r_we;
   logic [3:0]  r_bmask;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_if_ack;
   logic        r_ls_ack;
   logic [31:0] r_if_rdata;
   logic [31:0] r_ls_rdata;
   logic        r_err;

   logic        w_acc;
   logic        w_if_elig;
   logic        w_ls_elig;
   logic        w_gnt_ls;
   logic        w_gnt_if;
   logic        w_done;
   logic        w_tmo;

   // A requester whose ack is high this cycle is not eligible again yet.
   assign w_acc     = (r_state != S_IDLE);
   assign w_if_elig = if_req & ~r_if_ack;
   assign w_ls_elig = ls_req & ~r_ls_ack;
   assign w_gnt_ls  = w_ls_elig & (~w_if_elig | ~r_last_ls);
   assign w_gnt_if  = w_if_elig & ~w_gnt_ls;
   assign w_done    = w_acc & mem_ready;
   assign w_tmo     = w_acc & ~mem_ready & (r_cnt == LP_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state: grant from IDLE, return on completion or timeout.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_gnt_ls) begin
               w_next = S_LS;
            end else if (w_gnt_if) begin
               w_next = S_IF;
            end
         end
         S_IF, S_LS: begin
            if (w_done || w_tmo) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Memory command strobes are only live during an access.
   always_comb begin
      mem_req = w_acc;
      mem_we  = w_acc & r_we;
   end

   // Command latch, wait counter, acks, read data and sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_ls  <= 1'b0;
         r_cnt      <= 8'd0;
         r_we       <= 1'b0;
         r_bmask    <= 4'h0;
         r_addr     <= 32'h0;
         r_wdata    <= 32'h0;
         r_if_ack   <= 1'b0;
         r_ls_ack   <= 1'b0;
         r_if_rdata <= 32'h0;
         r_ls_rdata <= 32'h0;
         r_err      <= 1'b0;
      end else begin
         r_if_ack <= 1'b0;
         r_ls_ack <= 1'b0;
         if (r_state == S_IDLE) begin
            r_cnt <= 8'd0;
            if (w_gnt_ls) begin
               r_addr    <= ls_addr;
               r_we      <= ls_we;
               r_bmask   <= ls_bmask;
               r_wdata   <= ls_wdata;
               r_last_ls <= 1'b1;
            end else if (w_gnt_if) begin
               r_addr    <= if_addr;
               r_we      <= 1'b0;
               r_bmask   <= 4'hF;
               r_wdata   <= 32'h0;
               r_last_ls <= 1'b0;
            end
         end else if (w_done) begin
            if (r_state == S_IF) begin
               r_if_ack   <= 1'b1;
               r_if_rdata <= mem_rdata;
            end else begin
               r_ls_ack <= 1'b1;
               if (!r_we) begin
                  r_ls_rdata <= mem_rdata;
               end
            end
         end else if (w_tmo) begin
            r_err <= 1'b1;
            if (r_state == S_IF) begin
               r_if_ack   <= 1'b1;
               r_if_rdata <= 32'h0;
            end else begin
               r_ls_ack   <= 1'b1;
               r_ls_rdata <= 32'h0;
            end
         end else begin
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end

   assign mem_bmask = r_bmask;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign if_ack    = r_if_ack;
   assign ls_ack    = r_ls_ack;
   assign if_rdata  = r_if_rdata;
   assign ls_rdata  = r_ls_rdata;
   assign err       = r_err;
   assign stall_if  = if_req & ~r_if_ack;
   assign stall_mem = ls_req & ~r_ls_ack;

endmodule
